// File: rtl/ap2_ram_pkg.sv
// Shared definitions for AP2 RAM port arbiters.
// Holds the arbiter FSM encoding, RAM address/data widths and the RAM
// mode constants used when the block is wrapped as a 32-bit simple
// dual-port RAM.
package ap2_ram_pkg;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  // RAM mode settings for the wrapper: 32-bit read/write ports, RAM (not FIFO) mode.
  localparam logic [1:0] RMODE_32  = 2'b00;
  localparam logic [1:0] WMODE_32  = 2'b00;
  localparam logic       FMODE_RAM = 1'b0;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ap2_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  - request vector
//   ptr  - index searched first; search wraps modulo N
//   gnt  - one-hot grant (all zero when no request)
//   idx  - encoded index of the granted requester
//   any  - at least one request present
module ap2_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [PW:0] pos;
    pos = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract gives (ptr + k) mod N.
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        any                = 1'b1;
        idx                = pos[PW-1:0];
        gnt[pos[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ap2_ram_port_arbiter.sv
// Round-robin arbiter sharing one AP2 RAM (single-clock simple dual-port)
// between NREQ requesters, with idle power-down and wake-up stall.
// Ports:
//   CLK, CLR          - clock, asynchronous active-high reset
//   req/req_we        - per-requester request and write select
//   req_addr/wdata    - flattened per-requester address and write data
//   gnt               - combinational one-hot grant
//   rvalid/rdata      - one-hot read-data-valid pulse and read data
//   ram_*             - RAM control/data (registered), ram_rdata from RAM
//   busy              - FSM is sleeping or waking
module ap2_ram_port_arbiter
  import ap2_ram_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    ram_raddr,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_waddr,
  output logic             ram_wen,
  output logic [DW-1:0]    ram_wdata,
  input  logic [DW-1:0]    ram_rdata,
  output logic             ram_powerdn,
  output logic             busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic            ram_wen_q, ram_ren_q;
  logic [AW-1:0]   ram_waddr_q, ram_raddr_q;
  logic [DW-1:0]   ram_wdata_q;
  logic [PW-1:0]   rd_tag_q;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic          granted, grant_wr, grant_rd, in_flight;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  ap2_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gnt       = (state_q == ST_ACTIVE) ? pick_gnt : '0;
  assign granted   = (state_q == ST_ACTIVE) && pick_any;
  assign grant_wr  = granted && req_we[pick_idx];
  assign grant_rd  = granted && !req_we[pick_idx];
  assign sel_addr  = req_addr[AW*pick_idx +: AW];
  assign sel_wdata = req_wdata[DW*pick_idx +: DW];
  assign in_flight = ram_wen_q || ram_ren_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (pick_any) begin
          idle_cnt_d = '0;
          rr_ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (!in_flight) begin
          // Only count with an empty pipeline so no read is lost to power-down.
          if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
            state_d    = ST_SLEEP;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_SLEEP: begin
        if (|req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == WW'(WAKE_CYCLES - 1)) begin
          state_d    = ST_ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    rvalid_d = '0;
    if (ram_ren_q) rvalid_d[rd_tag_q] = 1'b1;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= ST_ACTIVE;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_wdata_q <= '0;
      rd_tag_q    <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ram_wen_q  <= grant_wr;
      ram_ren_q  <= grant_rd;
      rvalid_q   <= rvalid_d;
      if (grant_wr) begin
        ram_waddr_q <= sel_addr;
        ram_wdata_q <= sel_wdata;
      end
      if (grant_rd) begin
        ram_raddr_q <= sel_addr;
        rd_tag_q    <= pick_idx;
      end
    end
  end

  assign ram_wen     = ram_wen_q;
  assign ram_ren     = ram_ren_q;
  assign ram_waddr   = ram_waddr_q;
  assign ram_raddr   = ram_raddr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rvalid      = rvalid_q;
  assign ram_powerdn = (state_q == ST_SLEEP);
  assign busy        = (state_q != ST_ACTIVE);
  // The RAM output is already registered and lands in the rvalid cycle,
  // so it is forwarded directly to keep grant-to-data latency at two.
  assign rdata       = (|rvalid_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ap2_ram_port_arbiter.sv
module tb_ap2_ram_port_arbiter;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_we = '0;
  logic [43:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata, ram_wdata;
  logic [10:0] ram_raddr, ram_waddr;
  logic        ram_ren, ram_wen, ram_powerdn, busy;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [0:2047];

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  ap2_ram_port_arbiter u_dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ram_raddr   (ram_raddr),
    .ram_ren     (ram_ren),
    .ram_waddr   (ram_waddr),
    .ram_wen     (ram_wen),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_powerdn (ram_powerdn),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural synchronous RAM: data appears the cycle after REN is sampled.
  always @(posedge CLK) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge CLK) begin
    if (!CLR && rvalid != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {60'b0, rvalid}, 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rvalid_tag", {60'b0, rvalid}, 64'(1) << e.idx);
        chk("rdata", {32'b0, rdata}, {32'b0, e.data});
        chk("read_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_req(input int i, input bit we, input logic [10:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[11*i +: 11] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic push_read(input int i, input logic [31:0] d);
    exp_t e;
    e.idx = i;
    e.data = d;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  // Single access: wait (bounded) for the grant, then check the registered RAM controls.
  task automatic do_access(input int i, input bit we, input logic [10:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
    int n;
    @(negedge CLK);
    set_req(i, we, a, d);
    #1;
    n = 0;
    while (!gnt[i] && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("access_gnt", {60'b0, gnt}, 64'(1) << i);
    if (!we && gnt[i]) push_read(i, exp);
    @(negedge CLK);
    req[i] = 1'b0;
    #1;
    chk("access_wen", {63'b0, ram_wen}, {63'b0, we});
    chk("access_ren", {63'b0, ram_ren}, {63'b0, !we});
    if (we) begin
      chk("access_waddr", {53'b0, ram_waddr}, {53'b0, a});
      chk("access_wdata", {32'b0, ram_wdata}, {32'b0, d});
    end else begin
      chk("access_raddr", {53'b0, ram_raddr}, {53'b0, a});
    end
  endtask

  // Two simultaneous requests; i0 is expected to win first, i1 on the next cycle.
  task automatic do_pair(input int i0, input bit we0, input logic [10:0] a0,
                         input logic [31:0] d0, input logic [31:0] e0,
                         input int i1, input bit we1, input logic [10:0] a1,
                         input logic [31:0] d1, input logic [31:0] e1);
    @(negedge CLK);
    set_req(i0, we0, a0, d0);
    set_req(i1, we1, a1, d1);
    #1;
    chk("pair_first", {60'b0, gnt}, 64'(1) << i0);
    if (!we0 && gnt[i0]) push_read(i0, e0);
    @(negedge CLK);
    req[i0] = 1'b0;
    #1;
    chk("pair_second", {60'b0, gnt}, 64'(1) << i1);
    if (!we1 && gnt[i1]) push_read(i1, e1);
    @(negedge CLK);
    req[i1] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_gnt", {60'b0, gnt}, 64'h0);
    chk("rst_ren_wen", {62'b0, ram_ren, ram_wen}, 64'h0);
    chk("rst_rvalid", {60'b0, rvalid}, 64'h0);
    chk("rst_pd_busy", {62'b0, ram_powerdn, busy}, 64'h0);
    chk("rst_rdata", {32'b0, rdata}, 64'h0);
    chk("rst_addr", {42'b0, ram_waddr, ram_raddr}, 64'h0);

    // Fairness: all four requesting writes for 8 cycles
    @(negedge CLK);
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 11'h100 + 11'(i), 32'(i));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_gnt", {60'b0, gnt}, 64'(1) << (k % 4));
      if (k > 0) begin
        chk("fair_wen", {63'b0, ram_wen}, 64'h1);
        chk("fair_waddr", {53'b0, ram_waddr}, 64'h100 + 64'((k - 1) % 4));
      end
      @(negedge CLK);
    end
    req = '0;

    // Single write then read
    do_access(0, 1'b1, 11'h005, 32'hDEADBEEF, 32'h0);
    do_access(0, 1'b0, 11'h005, 32'h0, 32'hDEADBEEF);

    // Preload, then tag routing on consecutive reads
    do_access(2, 1'b1, 11'h010, 32'h10, 32'h0);
    do_access(3, 1'b1, 11'h011, 32'h11, 32'h0);
    do_pair(2, 1'b0, 11'h010, 32'h0, 32'h10, 3, 1'b0, 11'h011, 32'h0, 32'h11);

    // Read-after-write in consecutive grants
    do_pair(1, 1'b1, 11'h020, 32'hCAFE0001, 32'h0, 2, 1'b0, 11'h020, 32'h0, 32'hCAFE0001);

    // Pointer wrap: grant 3 alone, then 0 beats 3
    do_access(3, 1'b1, 11'h030, 32'h1, 32'h0);
    do_pair(0, 1'b1, 11'h031, 32'h2, 32'h0, 3, 1'b1, 11'h032, 32'h3, 32'h0);

    // Reset in the cycle after a read grant
    repeat (3) @(negedge CLK);
    set_req(1, 1'b0, 11'h005, 32'h0);
    #1;
    chk("rstmid_gnt", {60'b0, gnt}, 64'h2);
    @(negedge CLK);
    req = '0;
    #1;
    chk("rstmid_ren_before", {63'b0, ram_ren}, 64'h1);
    CLR = 1'b1;
    #1;
    chk("rstmid_ren_after", {63'b0, ram_ren}, 64'h0);
    @(negedge CLK);
    CLR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rstmid_no_rvalid", {60'b0, rvalid}, 64'h0);
      @(negedge CLK);
    end
    // rr_ptr back at 0: requester 1 beats 2 (a stale ptr of 2 would pick 2)
    do_pair(1, 1'b1, 11'h040, 32'h4, 32'h0, 2, 1'b1, 11'h041, 32'h5, 32'h0);

    // Power-down after 16 idle cycles from reset, then wake-up stall
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (15) @(negedge CLK);
    #1;
    chk("pd_before", {62'b0, ram_powerdn, busy}, 64'h0);
    @(negedge CLK);
    #1;
    chk("pd_asserted", {62'b0, ram_powerdn, busy}, 64'h3);
    set_req(1, 1'b0, 11'h005, 32'h0);
    #1;
    chk("sleep_gnt", {60'b0, gnt}, 64'h0);
    @(negedge CLK);
    #1;
    chk("wake_pd", {62'b0, ram_powerdn, busy}, 64'h1);
    chk("wake_gnt0", {60'b0, gnt}, 64'h0);
    @(negedge CLK);
    #1;
    chk("wake_gnt1", {60'b0, gnt}, 64'h0);
    @(negedge CLK);
    #1;
    chk("wake_done_gnt", {60'b0, gnt}, 64'h2);
    chk("wake_done_busy", {63'b0, busy}, 64'h0);
    if (gnt[1]) push_read(1, 32'hDEADBEEF);
    @(negedge CLK);
    req = '0;

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
